// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes four BCD digits onto a 4-digit
// common-anode seven-segment display from a frame-coherent snapshot.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   bcd       four BCD digits, digit i = bcd[4i+3:4i], digit 0 rightmost
//   dp        decimal-point request per digit, 1 = lit
//   blank_en  leading-zero blanking enable, used live (not snapshotted)
//   ssd_ctl   anode enables, active-low, one-hot-low, bit i = digit i
//   segs      cathodes, active-low, {a,b,c,d,e,f,g,dp}
module ssd_scan_driver #(
    parameter int SCAN_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp,
    input  logic        blank_en,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  segs
);

    localparam int PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_CNT - 1);

    logic [PW-1:0] pcnt;
    logic          tc;
    logic [1:0]    idx;
    logic [15:0]   snap_bcd;
    logic [3:0]    snap_dp;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    glyph;
    logic          z3, z2, z1;

    assign tc = (pcnt == PMAX);

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else begin
            pcnt <= tc ? '0 : pcnt + 1'b1;
            if (tc)
                idx <= idx + 2'd1;
        end
    end

    // Snapshot reloads only when leaving digit 3, so a frame never
    // shows a mix of old and new input values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_bcd <= 16'h0000;
            snap_dp  <= 4'b0000;
        end else if (tc && idx == 2'd3) begin
            snap_bcd <= bcd;
            snap_dp  <= dp;
        end
    end

    assign z3 = (snap_bcd[15:12] == 4'd0);
    assign z2 = (snap_bcd[11:8]  == 4'd0);
    assign z1 = (snap_bcd[7:4]   == 4'd0);

    // Digit select and blanking: a digit is blank only if it and all
    // digits to its left are zero; digit 0 always shows.
    always_comb begin
        digit = snap_bcd[3:0];
        blank = 1'b0;
        case (idx)
            2'd0: begin
                digit = snap_bcd[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                digit = snap_bcd[7:4];
                blank = blank_en & z3 & z2 & z1;
            end
            2'd2: begin
                digit = snap_bcd[11:8];
                blank = blank_en & z3 & z2;
            end
            default: begin
                digit = snap_bcd[15:12];
                blank = blank_en & z3;
            end
        endcase
    end

    // Segment decode {a..g}, active-low; non-BCD codes show a dash
    always_comb begin
        glyph = 7'b1111110;
        case (digit)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = 7'b1111110;
        endcase
        if (blank)
            glyph = 7'b1111111;
    end

    // Registered outputs keep the pins glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_ctl <= 4'b1111;
            segs    <= 8'hFF;
        end else begin
            ssd_ctl <= ~(4'b0001 << idx);
            segs    <= {glyph, ~snap_dp[idx]};
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed self-checking bench for ssd_scan_driver,
// one instance with SCAN_CNT=4 and one with SCAN_CNT=1.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst4_n, rst1_n;
    logic [15:0] bcd4, bcd1;
    logic [3:0]  dp4, dp1;
    logic        be4, be1;
    logic [3:0]  ctl4, ctl1;
    logic [7:0]  segs4, segs1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(.SCAN_CNT(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst4_n),
        .bcd      (bcd4),
        .dp       (dp4),
        .blank_en (be4),
        .ssd_ctl  (ctl4),
        .segs     (segs4)
    );

    ssd_scan_driver #(.SCAN_CNT(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst1_n),
        .bcd      (bcd1),
        .dp       (dp1),
        .blank_en (be1),
        .ssd_ctl  (ctl1),
        .segs     (segs1)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 16-cycle frame of dut4; optional input change at cycle chg_at
    task automatic frame4(input string tag,
                          input logic [7:0] e3, input logic [7:0] e2,
                          input logic [7:0] e1, input logic [7:0] e0,
                          input int chg_at,
                          input logic [15:0] nb, input logic [3:0] nd);
        logic [7:0] ev;
        logic [3:0] ec;
        for (int c = 0; c < 16; c++) begin
            step();
            ec = ~(4'b0001 << (c / 4));
            case (c / 4)
                0: ev = e0;
                1: ev = e1;
                2: ev = e2;
                default: ev = e3;
            endcase
            check($sformatf("%s_ctl_c%0d", tag, c), {4'h0, ctl4}, {4'h0, ec});
            check($sformatf("%s_segs_c%0d", tag, c), segs4, ev);
            if (c == chg_at) begin
                bcd4 = nb;
                dp4  = nd;
            end
        end
    endtask

    logic [7:0] dec_tbl [16];

    initial begin
        dec_tbl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                    8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
        rst4_n = 1'b0;
        rst1_n = 1'b0;
        bcd4 = 16'h4321;
        dp4  = 4'b0000;
        be4  = 1'b0;
        bcd1 = 16'h0000;
        dp1  = 4'b0000;
        be1  = 1'b0;

        // Reset held across clock edges
        repeat (3) @(negedge clk);
        check("rst_ctl4", {4'h0, ctl4}, 8'h0F);
        check("rst_segs4", segs4, 8'hFF);
        check("rst_ctl1", {4'h0, ctl1}, 8'h0F);
        check("rst_segs1", segs1, 8'hFF);

        // Scan order and snapshot coherence on SCAN_CNT=4
        rst4_n = 1'b1;
        frame4("f0", 8'h03, 8'h03, 8'h03, 8'h03, -1, 16'h0, 4'h0);
        frame4("f1", 8'h99, 8'h0D, 8'h25, 8'h9F, 3, 16'h1111, 4'h0);
        frame4("f2", 8'h9F, 8'h9F, 8'h9F, 8'h9F, 5, 16'h9999, 4'h0);
        frame4("f3", 8'h09, 8'h09, 8'h09, 8'h09, 2, 16'h0070, 4'h0);

        // Leading-zero blanking
        be4 = 1'b1;
        frame4("blk_on", 8'hFF, 8'hFF, 8'h1F, 8'h03, -1, 16'h0, 4'h0);
        be4 = 1'b0;
        frame4("blk_off", 8'h03, 8'h03, 8'h1F, 8'h03, 1, 16'h0000, 4'b1000);
        be4 = 1'b1;
        frame4("blk_dp", 8'hFE, 8'hFF, 8'hFF, 8'h03, -1, 16'h0, 4'h0);

        // Asynchronous reset at idx=2, pcnt=2
        repeat (10) step();
        #2 rst4_n = 1'b0;
        #1;
        check("arst_ctl", {4'h0, ctl4}, 8'h0F);
        check("arst_segs", segs4, 8'hFF);
        @(negedge clk);
        check("arst_hold_ctl", {4'h0, ctl4}, 8'h0F);
        check("arst_hold_segs", segs4, 8'hFF);
        rst4_n = 1'b1;
        frame4("post_rst", 8'hFF, 8'hFF, 8'hFF, 8'h03, -1, 16'h0, 4'h0);

        // Full decode sweep on SCAN_CNT=1, one code per frame
        rst1_n = 1'b1;
        for (int v = 0; v <= 16; v++) begin
            if (v < 16) begin
                bcd1 = {12'h000, 4'(v)};
                dp1  = (v == 3) ? 4'b0001 : 4'b0000;
            end
            for (int j = 0; j < 4; j++) begin
                step();
                check($sformatf("dec_ctl_v%0d_j%0d", v, j), {4'h0, ctl1},
                      {4'h0, ~(4'b0001 << j)});
                if (j == 0 && v > 0)
                    check($sformatf("dec_segs_%0d", v - 1), segs1,
                          dec_tbl[v-1] & ((v - 1 == 3) ? 8'hFE : 8'hFF));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Downstream display stage for the lab's BCD counters: takes four BCD digits plus per-digit decimal points and time-multiplexes them onto a 4-digit common-anode seven-segment display. It holds a frame-coherent snapshot of the inputs, with optional leading-zero blanking and a visible error glyph for non-BCD codes. The active-low outputs drive the board's anode and cathode pins directly.

## Interface
- SCAN_CNT, default 100000: clock cycles each digit is driven. Legal range ≥ 1.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd  input  16  four BCD digits. Digit i = bcd[4i+3:4i]; digit 0 is the rightmost.
- dp  input  4  decimal-point request; bit i belongs to digit i. 1 = lit.
- blank_en  input  1  enables leading-zero blanking. Sampled live, not snapshotted.
- ssd_ctl  output  4  anode enables, active-low, one-hot-low. Bit i selects digit i.
- segs  output  8  cathodes, active-low, order {a,b,c,d,e,f,g,dp}, with a at bit 7.

## Operation
- Prescaler pcnt counts 0..SCAN_CNT-1 and wraps to 0. Its width is $clog2(SCAN_CNT), minimum 1.
- Terminal count (tc) is asserted when pcnt == SCAN_CNT-1.
- Digit index idx (2 bits) advances 0→1→2→3→0 on every tc.
- Snapshot registers snap_bcd[15:0] and snap_dp[3:0] load bcd and dp on the edge where tc=1 and idx=3, i.e. the frame boundary. At all other times they hold.
- Inputs changing mid-frame must never appear on the display until the next frame.
- Decode of the selected snapshot digit into segs[7:1]:
  - 0=0000001
  - 1=1001111
  - 2=0010010
  - 3=0000110
  - 4=1001100
  - 5=0100100
  - 6=0100000
  - 7=0001111
  - 8=0000000
  - 9=0000100
  - 10–15 → 1111110 (dash, g only)
- segs[0] = ~snap_dp[idx].
- Leading-zero blanking: when blank_en=1, digit i (i=3,2,1) is blanked if snap_bcd digit i and every higher snapshot digit are all 0.
  - A blanked digit forces segs[7:1]=1111111.
  - The dp bit still follows snap_dp.
  - Digit 0 is never blanked.
- Outputs: ssd_ctl = ~(4'b0001 << idx) and segs = decoded value. Both are registered, so they are updated from idx and the snapshot one cycle after those change.

## Timing
- Reset values:
  - pcnt=0, idx=0
  - snap_bcd=16'h0000, snap_dp=4'b0000
  - ssd_ctl=4'b1111 (all digits off), segs=8'hFF
- First edge after rst_n rises: ssd_ctl=4'b1110, segs=8'b0000_0011 (digit 0 shows "0"; with blank_en=1, digits 3..1 are blank).
- Each digit is driven for exactly SCAN_CNT cycles. A full frame is 4·SCAN_CNT cycles.
- Output latency: one clock from an idx change to the ssd_ctl/segs change.
- A snapshot update becomes visible on digit 0 one cycle after the frame-boundary edge, i.e. together with ssd_ctl=4'b1110.
- SCAN_CNT=1: tc is constant 1, idx advances every cycle, and the snapshot loads every 4th cycle.
- Exactly one ssd_ctl bit is low at any time after the first post-reset edge. Glitch-free one-hot-low transitions are required, since the outputs are registered.
- Reset asserted mid-frame: all state clears immediately, without waiting for a clock. Outputs return to 1111/FF while rst_n=0.

## Test plan
- Reset: hold rst_n=0 and toggle clk → ssd_ctl=1111, segs=FF. Release rst_n → next edge gives ssd_ctl=1110, segs=00000011.
- Scan order, SCAN_CNT=4, bcd=16'h4321, dp=0:
  - First frame shows snapshot 0 and lasts 16 cycles.
  - Second frame shows ssd_ctl 1110/1101/1011/0111, each for 4 cycles, with segs "1","2","3","4" = 10011111, 00100101, 00001101, 10011001.
- Full decode, SCAN_CNT=1: sweep digit 0 through codes 0–15 across frames → the listed patterns. Codes 10–15 → 11111101.
- Blanking: bcd=16'h0070, blank_en=1 → digit 3 = FF, digit 2 = FF, digit 1 = 00011111, digit 0 = 00000011. The same input with blank_en=0 → digits 3 and 2 show 00000011. bcd=16'h0000 with dp=4'b1000 → digit 3 = 11111110.
- Snapshot coherence: change bcd from 16'h1111 to 16'h9999 while idx=1 → the remainder of the frame still shows "1". The next frame shows "9" on every digit.
- Reset mid-operation: assert rst_n=0 asynchronously while idx=2 and pcnt mid-count → outputs go to 1111/FF before the next clock edge. After release, the scan restarts at digit 0 and a full SCAN_CNT elapses before digit 1.
